// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encoding,
// chunk-width helper and the parameter legality check used at elaboration.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // WIDTH must split evenly into STAGES chunks of at least one bit each.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_stage.sv
// One carry-registered chunk of the pipelined adder: registered CW-bit sum,
// carry-out, running all-zero flag and valid bit; the top chunk also forms ovf.
module pipe_addsub_stage
  import addsub_pkg::*;
#(
  parameter int CW     = 4,
  parameter bit IS_TOP = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          vin,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          sub,
  input  logic          cin,
  input  logic          zin,
  output logic          vout,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          zout,
  output logic          ovf
);

  logic [CW-1:0] b_eff;
  logic [CW-1:0] sum_next;
  logic          cout_next;

  always_comb begin
    b_eff = (op_e'(sub) == OP_SUB) ? ~b : b;
    {cout_next, sum_next} = {1'b0, a} + {1'b0, b_eff} + {{CW{1'b0}}, cin};
  end

  // zout accumulates "every chunk so far is zero" alongside the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      zout <= 1'b0;
    end else if (en) begin
      vout <= vin;
      sum  <= sum_next;
      cout <= cout_next;
      zout <= zin && (sum_next == '0);
    end
  end

  generate
    if (IS_TOP) begin : g_ovf
      logic cmsb;
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign cmsb = a[CW-1] ^ b_eff[CW-1] ^ sum_next[CW-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf <= 1'b0;
        end else if (en) begin
          ovf <= cmsb ^ cout_next;
        end
      end
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-registered chunks,
// with skewed operands, deskewed sum chunks and a valid/ready handshake.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  generate
    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be >= 2, STAGES in 1..WIDTH, WIDTH divisible by STAGES");
    end
  endgenerate

  logic              en;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_carry;
  logic [STAGES-1:0] stage_zero;
  logic [STAGES-1:0] stage_ovf;
  logic [CW-1:0]     stage_sum [STAGES];

  // The whole pipeline moves as one unit, so a stall at the output freezes every stage.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = stage_valid[STAGES-1];
  assign cout      = stage_carry[STAGES-1];
  assign zero      = stage_zero[STAGES-1];
  assign ovf       = |stage_ovf;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [CW-1:0] a_st;
      logic [CW-1:0] b_st;
      logic          sub_st;
      logic          cin_st;
      logic          vin_st;
      logic          zin_st;

      if (gi == 0) begin : g_first
        assign a_st   = a[CW-1:0];
        assign b_st   = b[CW-1:0];
        assign sub_st = sub;
        assign cin_st = (op_e'(sub) == OP_SUB) ? 1'b1 : cin;
        assign vin_st = in_valid;
        assign zin_st = 1'b1;
      end else begin : g_skew
        // Chunk gi waits gi cycles so it meets the carry of its own beat.
        logic [CW-1:0] a_sk   [gi];
        logic [CW-1:0] b_sk   [gi];
        logic          sub_sk [gi];

        always_ff @(posedge clk) begin
          if (en) begin
            a_sk[0]   <= a[gi*CW +: CW];
            b_sk[0]   <= b[gi*CW +: CW];
            sub_sk[0] <= sub;
            for (int k = 1; k < gi; k++) begin
              a_sk[k]   <= a_sk[k-1];
              b_sk[k]   <= b_sk[k-1];
              sub_sk[k] <= sub_sk[k-1];
            end
          end
        end

        assign a_st   = a_sk[gi-1];
        assign b_st   = b_sk[gi-1];
        assign sub_st = sub_sk[gi-1];
        assign cin_st = stage_carry[gi-1];
        assign vin_st = stage_valid[gi-1];
        assign zin_st = stage_zero[gi-1];
      end

      pipe_addsub_stage #(
        .CW     (CW),
        .IS_TOP (gi == STAGES - 1)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .vin   (vin_st),
        .a     (a_st),
        .b     (b_st),
        .sub   (sub_st),
        .cin   (cin_st),
        .zin   (zin_st),
        .vout  (stage_valid[gi]),
        .sum   (stage_sum[gi]),
        .cout  (stage_carry[gi]),
        .zout  (stage_zero[gi]),
        .ovf   (stage_ovf[gi])
      );

      if (gi < STAGES - 1) begin : g_deskew
        localparam int D = STAGES - 1 - gi;
        logic [CW-1:0] ds [D];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < D; k++) ds[k] <= '0;
          end else if (en) begin
            ds[0] <= stage_sum[gi];
            for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
          end
        end

        assign sum[gi*CW +: CW] = ds[D-1];
      end else begin : g_last
        assign sum[gi*CW +: CW] = stage_sum[gi];
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and swept checks of pipe_addsub: 16/4 table vectors, streaming with
// backpressure, reset mid-flight, plus 4/1 exhaustive and 32/8 random sweeps.
module tb_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  // Reference: returns {sum[31:0], cout, ovf, zero} for a w-bit operation.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] mask, bb, s;
    logic [32:0] full;
    logic        co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bb   = sub ? (~b & mask) : b;
    full = {1'b0, a} + {1'b0, bb} + (sub ? 33'd1 : {32'd0, cin});
    s    = full[31:0] & mask;
    co   = full[w];
    if (sub) ov = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
    else     ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {s, co, ov, (s == 32'd0)};
  endfunction

  // ---------------- main DUT, WIDTH=16 STAGES=4 ----------------
  logic        rst_n, m_in_valid, m_in_ready, m_cin, m_sub;
  logic        m_out_valid, m_out_ready, m_cout, m_ovf, m_zero;
  logic [15:0] m_a, m_b, m_sum;

  pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .cout(m_cout), .ovf(m_ovf), .zero(m_zero)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs [10];

  task automatic single_beat(input vec_t v, input string tag);
    int lat;
    m_a = v.a; m_b = v.b; m_cin = v.cin; m_sub = v.sub; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_res"}, {m_sum, m_cout, m_ovf, m_zero}, {v.s, v.co, v.ov, v.z});
    @(posedge clk); #1;
  endtask

  // ---------------- sweep DUTs ----------------
  logic        rst_sw_n;
  logic        d4_in_valid, d4_in_ready, d4_cin, d4_sub, d4_out_valid, d4_cout, d4_ovf, d4_zero;
  logic [3:0]  d4_a, d4_b, d4_sum;
  logic        d32_in_valid, d32_in_ready, d32_cin, d32_sub, d32_out_valid, d32_cout, d32_ovf, d32_zero;
  logic [31:0] d32_a, d32_b, d32_sum;
  logic        done4 = 1'b0, done32 = 1'b0;

  pipe_addsub #(.WIDTH(4), .STAGES(1)) dut4 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .a(d4_a), .b(d4_b), .cin(d4_cin), .sub(d4_sub),
    .out_valid(d4_out_valid), .out_ready(1'b1),
    .sum(d4_sum), .cout(d4_cout), .ovf(d4_ovf), .zero(d4_zero)
  );

  pipe_addsub #(.WIDTH(32), .STAGES(8)) dut32 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
    .a(d32_a), .b(d32_b), .cin(d32_cin), .sub(d32_sub),
    .out_valid(d32_out_valid), .out_ready(1'b1),
    .sum(d32_sum), .cout(d32_cout), .ovf(d32_ovf), .zero(d32_zero)
  );

  typedef struct packed {
    logic [34:0] exp;
    int          acc;
  } sb_t;

  sb_t q4 [$];
  sb_t q32 [$];
  sb_t e4, e32;

  initial begin
    d4_in_valid = 1'b0; d4_a = '0; d4_b = '0; d4_cin = 1'b0; d4_sub = 1'b0;
    wait (rst_sw_n);
    @(posedge clk); #1;
    for (int x = 0; x < 1024; x++) begin
      d4_a = x[3:0]; d4_b = x[7:4]; d4_cin = x[8]; d4_sub = x[9];
      d4_in_valid = 1'b1;
      @(posedge clk); #1;
      q4.push_back('{model(4, {28'd0, d4_a}, {28'd0, d4_b}, d4_cin, d4_sub), cyc});
    end
    d4_in_valid = 1'b0;
    for (int n = 0; n < 50 && q4.size() != 0; n++) @(posedge clk);
    done4 = 1'b1;
  end

  initial begin
    d32_in_valid = 1'b0; d32_a = '0; d32_b = '0; d32_cin = 1'b0; d32_sub = 1'b0;
    wait (rst_sw_n);
    @(posedge clk); #1;
    for (int n = 0; n < 10000; n++) begin
      d32_a   = $urandom;
      d32_b   = (n % 7 == 0) ? d32_a : ((n % 11 == 0) ? ~d32_a : $urandom);
      d32_cin = 1'($urandom_range(0, 1));
      d32_sub = 1'($urandom_range(0, 1));
      d32_in_valid = 1'b1;
      @(posedge clk); #1;
      q32.push_back('{model(32, d32_a, d32_b, d32_cin, d32_sub), cyc});
    end
    d32_in_valid = 1'b0;
    for (int n = 0; n < 50 && q32.size() != 0; n++) @(posedge clk);
    done32 = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_sw_n && d4_out_valid) begin
      if (q4.size() == 0) begin
        vectors++; errors++;
        $display("FAIL w4_spurious: got out_valid=1, want no result pending");
      end else begin
        e4 = q4.pop_front();
        chk("w4_res", {28'd0, d4_sum, d4_cout, d4_ovf, d4_zero}, e4.exp);
        chk("w4_lat", cyc - e4.acc, 0);
      end
    end
    if (rst_sw_n && d32_out_valid) begin
      if (q32.size() == 0) begin
        vectors++; errors++;
        $display("FAIL w32_spurious: got out_valid=1, want no result pending");
      end else begin
        e32 = q32.pop_front();
        chk("w32_res", {d32_sum, d32_cout, d32_ovf, d32_zero}, e32.exp);
        chk("w32_lat", cyc - e32.acc, 7);
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [15:0] st_a [8];
  logic [15:0] st_b [8];
  logic        st_cin [8];
  logic        st_sub [8];
  logic [34:0] st_exp [8];
  logic [18:0] held;
  logic        held_valid, acc;
  int          idx, got, extra, n;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      st_a[i]   = 16'(i * 16'h2345);
      st_b[i]   = 16'(16'hFFFF - i * 16'h1111);
      st_cin[i] = i[0];
      st_sub[i] = i[1];
      st_exp[i] = model(16, {16'd0, st_a[i]}, {16'd0, st_b[i]}, st_cin[i], st_sub[i]);
    end

    rst_n = 1'b0; rst_sw_n = 1'b0;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_sum_flags", {m_sum, m_cout, m_ovf, m_zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst_sw_n = 1'b1;
    chk("rst_in_ready", m_in_ready, 1);
    m_out_ready = 1'b1;

    for (int i = 0; i < 10; i++) single_beat(vecs[i], $sformatf("v%0d", i));

    // Streaming: 8 beats back to back, output stalled for cycles 5..7.
    idx = 0; got = 0; held_valid = 1'b0; held = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      m_out_ready = !(c >= 5 && c <= 7);
      m_in_valid  = (idx < 8);
      if (idx < 8) begin
        m_a = st_a[idx]; m_b = st_b[idx]; m_cin = st_cin[idx]; m_sub = st_sub[idx];
      end
      @(negedge clk);
      if (m_out_valid && !m_out_ready) begin
        chk($sformatf("bp_in_ready_c%0d", c), m_in_ready, 0);
        if (held_valid) chk($sformatf("bp_hold_c%0d", c), {m_sum, m_cout, m_ovf, m_zero}, held);
        held = {m_sum, m_cout, m_ovf, m_zero};
        held_valid = 1'b1;
      end else begin
        held_valid = 1'b0;
      end
      acc = m_in_valid && m_in_ready;
      if (m_out_valid && m_out_ready) begin
        chk($sformatf("st%0d", got), {16'h0000, m_sum, m_cout, m_ovf, m_zero}, st_exp[got]);
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    m_in_valid = 1'b0;
    chk("st_count", got, 8);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_out_valid) extra++;
      @(posedge clk); #1;
    end
    chk("st_no_dup", extra, 0);

    // Reset with three beats in flight and the first one stalled at the output.
    m_out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      m_a = (j == 0) ? 16'hFFFF : 16'(j); m_b = (j == 0) ? 16'h0001 : 16'(j);
      m_cin = 1'b0; m_sub = 1'b0; m_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    m_in_valid = 1'b0;
    n = 0;
    while (!m_out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_rst_valid", m_out_valid, 1);
    chk("pre_rst_flags", {m_cout, m_zero}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_out_valid, 0);
    chk("async_rst_sum_flags", {m_sum, m_cout, m_ovf, m_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    single_beat(vecs[0], "post_rst");
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_out_valid) extra++;
      @(posedge clk); #1;
    end
    chk("post_rst_no_stale", extra, 0);

    for (int k = 0; k < 30000 && !(done4 && done32); k++) @(posedge clk);
    chk("sweep_done", {done4, done32}, 2'b11);
    chk("sweep_drained", q4.size() + q32.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple adder.
- Computes A+B+cin or A−B over WIDTH bits, split into STAGES carry-registered chunks.
- Valid/ready handshake on both sides; outputs carry-out, signed overflow and zero flags.
- Used as the arithmetic datapath core wherever wide adds must close timing at a high clock rate.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 2 and divisible by STAGES.
- STAGES, 4, number of pipeline register stages; chunk width CW = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: A+B+cin; 1: A+~B+1
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result modulo 2^WIDTH
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow (A ≥ B unsigned)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit, sum, cout, ovf, zero and out_valid go to 0 immediately. in_ready is 1 once reset is released. In-flight beats are discarded, with no partial output.
- Global advance enable: en = !out_valid || out_ready; in_ready = en (combinational; there is no combinational path from in_valid).
- A beat is accepted on a rising edge where in_valid && in_ready. When en=0 all stage registers hold; an offered beat is not accepted and must stay stable.
- Stage s (0..STAGES-1) adds chunk s, bits [s*CW +: CW], using the carry registered by stage s−1. The stage-0 carry-in is cin (sub=0) or 1 (sub=1). B is inverted when sub=1.
- Upper operand chunks and the sub bit are skewed through delay registers so each chunk meets its carry. Lower sum chunks are deskewed so all chunks emerge aligned.
- Latency: out_valid rises right after the (STAGES)th enabled edge, counting the accepting edge as the first. STAGES=1 gives a fully registered single-cycle adder.
- Throughput: one beat per cycle when out_ready is held high. Bubbles (in_valid=0) propagate as invalid slots and are not collapsed.
- Stage valid bits shift on en. Invalid slots still clock their data registers; their contents are don't-care and are never presented.
- ovf, cout and zero are computed in the last stage and registered alongside sum. All four update only on an enabled edge.
- Backpressure: while out_valid && !out_ready, sum and all flags hold stable and no stage advances.
- Simultaneous: out_valid && out_ready && in_valid on the same edge: the output is consumed and the pipeline shifts in one step, with no lost or duplicated beat.
- Wrap-around: the sum is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Decomposition:
- Shared package addsub_pkg holds:
  - constant function chunk_w(WIDTH, STAGES);
  - an elaboration-time check that WIDTH % STAGES == 0;
  - typedef op_e {OP_ADD=0, OP_SUB=1}.
- One sub-module, pipe_addsub_stage, holds:
  - the registered CW-bit chunk adder (its carry-in, sum chunk and carry-out register);
  - the valid bit;
  - for the top stage only, the carry-into-MSB tap used for ovf.
- The top level instantiates STAGES stages via generate and builds the skew/deskew delay lines.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Reset then single add: a=0x1234, b=0x4321, cin=0 → out_valid after 4 edges; sum=0x5555, cout=0, ovf=0, zero=0.
- Carry ripple across all chunks: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, zero=1. Add a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0.
- Subtract: sub=1, a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1, cout=1.
- Streaming with backpressure: 8 back-to-back beats, out_ready low for 3 cycles mid-stream → in_ready low in the same cycles, sum/flags held stable, all 8 results in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight → out_valid and flags drop at once with no clock edge needed; after release, the next beat returns with standard latency and the stale beats never appear.
- Parameter sweep: WIDTH=4/STAGES=1 (exhaustive 512 vectors incl. cin) and WIDTH=32/STAGES=8 (random 10k) → every result matches a reference model, and latency equals STAGES.
